// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU controller: op encoding, FSM states
// and the default operand width.
package alu_pkg;

    localparam int ALU_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Only ADD and SUB propagate a meaningful carry out of the cell chain.
    function automatic logic op_has_carry(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_cell.sv
// One-bit ALU slice: NOR, XOR, full-add, or full-add with inverted b
// (subtract). The carry output is held at 0 for the logic ops.
module alu_serial_ctrl_cell
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       s,
    output logic       cout
);

    logic b_eff;

    always_comb begin
        s     = 1'b0;
        cout  = 1'b0;
        b_eff = b;
        case (alu_op_e'(op))
            OP_NOR: s = ~(a | b);
            OP_XOR: s = a ^ b;
            OP_ADD: begin
                s    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB: begin
                // a - b computed as a + ~b + 1; the +1 arrives via cin = 1.
                b_eff = ~b;
                s     = a ^ b_eff ^ cin;
                cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            default: begin
                s    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: latches operands on start, pushes one bit per
// cycle (LSB first) through a single 1-bit cell, then pulses done.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a request pulse that is only taken when busy is low
    // and the FSM is idle; busy rises on the accepting edge and stays high
    // through the done cycle; done is a single-cycle pulse during which result
    // and cout are valid (both then hold until the next accepted start).

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] TERM = CW'(WIDTH - 1);

    state_e           state;
    logic             armed;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    alu_op_e          op_q;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             cell_s;
    logic             cell_cout;
    logic [WIDTH-1:0] res_next;

    alu_serial_ctrl_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .op   (op_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

    assign res_next  = {cell_s, res_sh[WIDTH-1:1]};
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            armed  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cout   <= 1'b0;
            result <= '0;
            res_sh <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            op_q   <= OP_NOR;
            cnt    <= '0;
            carry  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The accepting cycle only loads operands; bit work starts
                    // once the FSM has moved to RUN.
                    if (armed) begin
                        armed <= 1'b0;
                        state <= ST_RUN;
                    end else if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_q  <= alu_op_e'(op);
                        cnt   <= '0;
                        carry <= (alu_op_e'(op) == OP_SUB);
                        armed <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= cell_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == TERM) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= res_next;
                        cout   <= op_has_carry(op_q) ? cell_cout : 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 NOR, 01 XOR, 10 ADD, 11 SUB (a-b); sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress, including the DONE cycle.
REQ-009 done  output  1  one-cycle pulse; result and cout are valid in this cycle.
REQ-010 result  output  WIDTH  registered result; holds its value until the next accepted start.
REQ-011 cout  output  1  registered final carry; for SUB, 1 means no borrow; 0 for NOR and XOR.

Function
REQ-012 The block computes one result bit per cycle, LSB first, through a single instance of the 1-bit ALU cell (inputs a, b, cin, op; outputs s, cout).
REQ-013 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 On start in IDLE: latch a, b and op into shift registers; clear the bit counter to 0; set the carry flop to 1 for SUB and to 0 otherwise.
REQ-015 Each RUN cycle: present a_sh[0], b_sh[0], the carry flop and op_q to the cell; shift the cell's s into the result MSB (shift right); shift both operands right by one; load the carry flop from the cell's cout; increment the counter.
REQ-016 RUN lasts exactly WIDTH cycles; counter width is $clog2(WIDTH)+1; terminal count is WIDTH-1.
REQ-017 Latency: with start high at edge k, done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after acceptance.
REQ-018 In DONE: assert done; cout = carry flop for ADD and SUB, forced to 0 for NOR and XOR; update result and cout only on entry to DONE.
REQ-019 start is ignored while busy; the operation in flight and its operands are unaffected.
REQ-020 start high in the DONE cycle is ignored; a new start is accepted only from IDLE, one cycle later at the earliest.
REQ-021 op, a and b changing after acceptance have no effect.
REQ-022 Arithmetic is modulo 2^WIDTH; overflow is not flagged.
REQ-023 The cell's combinational gate delays settle within a single clock period; the bench clock period is at least 100 time units.

Reset
REQ-024 While rst_n is low at a rising edge: state becomes IDLE; busy, done and cout become 0; result, counter, carry flop and shift registers become 0.
REQ-025 If reset is asserted mid-RUN or in DONE, the operation is aborted, no done pulse is produced, and start is accepted on the first edge after rst_n returns high.

Structure
REQ-026 Package alu_pkg holds the op encoding enum (OP_NOR, OP_XOR, OP_ADD, OP_SUB), the FSM state enum, and the WIDTH default constant.
REQ-027 The 1-bit ALU cell is the only sub-module, instantiated once; the datapath uses no other arithmetic operators.

Verification (WIDTH=8)
REQ-028 ADD a=0x7F b=0x01 -> done exactly 10 cycles after the start edge, result=0x80, cout=0.
REQ-029 ADD a=0xFF b=0x01 -> result=0x00, cout=1; SUB a=0x05 b=0x07 -> result=0xFE, cout=0; SUB a=0x07 b=0x05 -> result=0x02, cout=1.
REQ-030 XOR a=0xA5 b=0x0F -> result=0xAA, cout=0; NOR a=0xF0 b=0x0C -> result=0x03, cout=0.
REQ-031 Start ADD 0x01+0x01, then pulse start with SUB 0x00-0x01 at cycle 3 -> exactly one done, result=0x02; the second start is ignored.
REQ-032 rst_n low at cycle 4 of RUN -> next cycle busy=0, done=0, result=0x00; no done pulse follows; a fresh ADD 0x10+0x20 then yields 0x30.
REQ-033 Back-to-back operation: start held high continuously -> operations accepted every WIDTH+3 cycles, with one done pulse per accepted operation.
